alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the datapath ALU.
- Registers every result.
- Adds arithmetic shift right and an iterative multi-cycle unsigned multiply.
- Reports zero, carry/borrow, signed overflow and illegal-opcode flags.
- Sits between the decode/issue stage and the writeback stage of the MIPS core.
- Uses valid/ready on both sides, so the multi-cycle multiply can stall issue.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_pipe.sv | 163 ++++++++++++++++
 tb/tb_alu_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the pipelined ALU.
// The MUL opcode is only decoded as legal when ALU_PIPE_MUL_EN is defined.
package alu_pkg;

   localparam logic [5:0] FN_ADD = 6'd27;
   localparam logic [5:0] FN_SUB = 6'd28;
   localparam logic [5:0] FN_SRL = 6'd29;
   localparam logic [5:0] FN_SLL = 6'd30;
   localparam logic [5:0] FN_XOR = 6'd31;
   localparam logic [5:0] FN_AND = 6'd32;
   localparam logic [5:0] FN_SRA = 6'd33;
   localparam logic [5:0] FN_MUL = 6'd34;

   typedef enum logic [0:0] {
      IDLE,
      MUL_BUSY
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps.
// Instantiated by alu_pipe only when ALU_PIPE_MUL_EN is defined.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic [WIDTH:0]   w_sum;
   logic             w_done;

   // r_lo starts as the multiplier and fills with product bits as it shifts right.
   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
   assign w_done = r_busy && (r_cnt == CW'(WIDTH - 1));

   // Products of the final step, valid in the cycle o_done is high.
   assign o_done = w_done;
   assign o_hi   = w_sum[WIDTH:1];
   assign o_lo   = {w_sum[0], r_lo[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else if (i_start) begin
         r_mcand <= i_a;
         r_hi    <= '0;
         r_lo    <= i_b;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         r_hi  <= w_sum[WIDTH:1];
         r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + 1'b1;
         if (w_done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked registered ALU between issue and writeback.
// Define ALU_PIPE_MUL_EN to enable the iterative multi-cycle MUL (funct 34).
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         funct,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [WIDTH-1:0]   result_hi,
   output logic               zero,
   output logic               carry,
   output logic               overflow,
   output logic               err
);

   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_ovf;
   logic             r_err;
   logic             r_out_valid;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;
   logic             w_err;
   logic             w_accept;
   logic             w_load_single;
   logic             w_is_mul;
   logic             w_mul_done;
   logic             w_idle;
   logic [WIDTH-1:0] w_mul_lo;

   always_comb begin
      w_sum   = '0;
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      case (funct)
         FN_ADD: begin
            w_sum   = {1'b0, src1} + {1'b0, src2};
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (src1[WIDTH-1] == src2[WIDTH-1]) && (w_res[WIDTH-1] != src1[WIDTH-1]);
         end
         FN_SUB: begin
            // Bit WIDTH of the extended difference is the borrow.
            w_sum   = {1'b0, src1} - {1'b0, src2};
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (src1[WIDTH-1] != src2[WIDTH-1]) && (w_res[WIDTH-1] != src1[WIDTH-1]);
         end
         FN_SRL: w_res = src1 >> shamt;
         FN_SLL: w_res = src1 << shamt;
         FN_SRA: w_res = $unsigned($signed(src1) >>> shamt);
         FN_XOR: w_res = src1 ^ src2;
         FN_AND: w_res = src1 & src2;
`ifdef ALU_PIPE_MUL_EN
         FN_MUL: w_err = 1'b0;
`endif
         default: w_err = 1'b1;
      endcase
   end

   assign in_ready      = rst_n && w_idle && (!r_out_valid || out_ready);
   assign w_accept      = in_valid && in_ready;
   assign w_load_single = w_accept && !w_is_mul;

`ifdef ALU_PIPE_MUL_EN
   state_e           r_state;
   state_e           w_state_d;
   logic [WIDTH-1:0] r_result_hi;
   logic [WIDTH-1:0] w_mul_hi;

   assign w_is_mul = (funct == FN_MUL);
   assign w_idle   = (r_state == IDLE);

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_start(w_accept && w_is_mul),
      .i_a    (src1),
      .i_b    (src2),
      .o_done (w_mul_done),
      .o_lo   (w_mul_lo),
      .o_hi   (w_mul_hi)
   );

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         IDLE:     if (w_accept && w_is_mul) w_state_d = MUL_BUSY;
         MUL_BUSY: if (w_mul_done) w_state_d = IDLE;
         default:  w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_result_hi <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_load_single)   r_result_hi <= '0;
         else if (w_mul_done) r_result_hi <= w_mul_hi;
      end
   end

   assign result_hi = r_result_hi;
`else
   assign w_is_mul   = 1'b0;
   assign w_mul_done = 1'b0;
   assign w_mul_lo   = '0;
   assign w_idle     = 1'b1;
   assign result_hi  = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_load_single) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_ovf    <= w_ovf;
            r_err    <= w_err;
         end else if (w_mul_done) begin
            r_result <= w_mul_lo;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
         end
         // Accept implies the slot is empty or drained this cycle, so a MUL accept clears it.
         r_out_valid <= w_load_single || w_mul_done || (r_out_valid && !out_ready);
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = (r_result == '0);
   assign carry     = r_carry;
   assign overflow  = r_ovf;
   assign err       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe; MUL expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] hi;
      logic        z;
      logic        c;
      logic        v;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [31:0] result_hi;
   logic        zero;
   logic        carry;
   logic        overflow;
   logic        err;

   int   checks = 0;
   int   errors = 0;
   logic last_acc;
   logic last_pop;
   exp_t sb[$];
   exp_t nil;

   always #5 clk = ~clk;

   alu_pipe #(
      .WIDTH(32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .funct    (funct),
      .shamt    (shamt),
      .src1     (src1),
      .src2     (src2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .result_hi(result_hi),
      .zero     (zero),
      .carry    (carry),
      .overflow (overflow),
      .err      (err)
   );

   function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                               input logic z, input logic c, input logic v, input logic e);
      exp_t x;
      x.res = r; x.hi = h; x.z = z; x.c = c; x.v = v; x.e = e;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("result", 64'(result), 64'(e.res));
         chk("result_hi", 64'(result_hi), 64'(e.hi));
         chk("zero", 64'(zero), 64'(e.z));
         chk("carry", 64'(carry), 64'(e.c));
         chk("overflow", 64'(overflow), 64'(e.v));
         chk("err", 64'(err), 64'(e.e));
      end
   endtask

   // One cycle: drive at negedge, score a consume, record an accept for the next posedge.
   task automatic cyc(input logic iv, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input logic ordy, input exp_t e);
      @(negedge clk);
      in_valid = iv; funct = fn; shamt = sh; src1 = a; src2 = b; out_ready = ordy;
      #1;
      last_pop = out_valid && out_ready;
      if (last_pop) pop_check();
      last_acc = in_valid && in_ready;
      if (last_acc) sb.push_back(e);
   endtask

   initial begin
      int lat;
      nil = mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      funct = FN_ADD; shamt = '0; src1 = '0; src2 = '0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_result_hi", 64'(result_hi), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      chk("rst_flags", 64'({carry, overflow, err}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back single-cycle ops at full throughput.
      cyc(1, FN_ADD, 0, 32'hFFFF_FFFF, 32'h1, 1, mk(32'h0, 0, 1, 1, 0, 0));
      chk("acc_add", 64'(last_acc), 64'd1);
      cyc(1, FN_ADD, 0, 32'h7FFF_FFFF, 32'h1, 1, mk(32'h8000_0000, 0, 0, 0, 1, 0));
      chk("acc_add_ovf", 64'(last_acc), 64'd1); chk("pop_1", 64'(last_pop), 64'd1);
      cyc(1, FN_SUB, 0, 32'h3, 32'h5, 1, mk(32'hFFFF_FFFE, 0, 0, 1, 0, 0));
      chk("acc_sub", 64'(last_acc), 64'd1); chk("pop_2", 64'(last_pop), 64'd1);
      cyc(1, FN_SUB, 0, 32'h8000_0000, 32'h1, 1, mk(32'h7FFF_FFFF, 0, 0, 0, 1, 0));
      chk("acc_sub_ovf", 64'(last_acc), 64'd1); chk("pop_3", 64'(last_pop), 64'd1);
      cyc(1, FN_SRA, 4, 32'h8000_0000, 32'h0, 1, mk(32'hF800_0000, 0, 0, 0, 0, 0));
      chk("acc_sra", 64'(last_acc), 64'd1); chk("pop_4", 64'(last_pop), 64'd1);
      cyc(1, FN_SRL, 4, 32'h8000_0000, 32'h0, 1, mk(32'h0800_0000, 0, 0, 0, 0, 0));
      chk("acc_srl", 64'(last_acc), 64'd1); chk("pop_5", 64'(last_pop), 64'd1);
      cyc(1, FN_SLL, 4, 32'h8000_0001, 32'h0, 1, mk(32'h0000_0010, 0, 0, 0, 0, 0));
      chk("acc_sll", 64'(last_acc), 64'd1); chk("pop_6", 64'(last_pop), 64'd1);
      cyc(1, FN_XOR, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, mk(32'h0FF0_0FF0, 0, 0, 0, 0, 0));
      chk("acc_xor", 64'(last_acc), 64'd1); chk("pop_7", 64'(last_pop), 64'd1);
      cyc(1, FN_AND, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, mk(32'hF000_F000, 0, 0, 0, 0, 0));
      chk("acc_and", 64'(last_acc), 64'd1); chk("pop_8", 64'(last_pop), 64'd1);
      cyc(0, FN_ADD, 0, 0, 0, 1, nil);
      chk("pop_9", 64'(last_pop), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef ALU_PIPE_MUL_EN
      cyc(1, FN_MUL, 0, 32'h0001_0000, 32'h0001_0000, 1, mk(32'h0, 32'h1, 1, 0, 0, 0));
      chk("acc_mul", 64'(last_acc), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; funct = FN_ADD; out_ready = 1'b0;
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
         chk("mul_in_ready", 64'(in_ready), 64'd0);
      end
      chk("mul_latency", 64'(lat), 64'd32);
      cyc(0, FN_ADD, 0, 0, 0, 1, nil);
      chk("pop_mul", 64'(last_pop), 64'd1);
`else
      cyc(1, FN_MUL, 0, 32'h0001_0000, 32'h0001_0000, 1, mk(32'h0, 32'h0, 1, 0, 0, 1));
      chk("acc_mul_illegal", 64'(last_acc), 64'd1);
      cyc(0, FN_ADD, 0, 0, 0, 1, nil);
      chk("pop_mul_illegal", 64'(last_pop), 64'd1);
`endif

      // Backpressure: XOR result held while the consumer stalls for 5 cycles.
      cyc(1, FN_XOR, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      chk("acc_xor_bp", 64'(last_acc), 64'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(1, FN_AND, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, mk(32'h0F0F_0000, 0, 0, 0, 0, 0));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_result", 64'(result), 64'hFFFF_FFFF);
         chk("bp_flags", 64'({zero, carry, overflow, err}), 64'd0);
      end
      cyc(1, FN_AND, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, mk(32'h0F0F_0000, 0, 0, 0, 0, 0));
      chk("bp_release_pop", 64'(last_pop), 64'd1);
      chk("bp_release_acc", 64'(last_acc), 64'd1);
      cyc(0, FN_ADD, 0, 0, 0, 1, nil);
      chk("pop_and", 64'(last_pop), 64'd1);

      // Async reset with an operation in flight.
`ifdef ALU_PIPE_MUL_EN
      cyc(1, FN_MUL, 0, 32'h1234, 32'h5678, 1, nil);
`else
      cyc(1, FN_ADD, 0, 32'h1, 32'h1, 0, nil);
`endif
      chk("acc_inflight", 64'(last_acc), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_result", 64'({result_hi, result}), 64'd0);
      chk("mid_rst_zero", 64'(zero), 64'd1);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      cyc(1, FN_ADD, 0, 32'h5, 32'h7, 1, mk(32'hC, 0, 0, 0, 0, 0));
      chk("acc_add_rel", 64'(last_acc), 64'd1);
      cyc(1, 6'd40, 0, 32'h5, 32'h7, 1, mk(32'h0, 0, 1, 0, 0, 1));
      chk("acc_illegal", 64'(last_acc), 64'd1); chk("pop_add_rel", 64'(last_pop), 64'd1);
      cyc(1, FN_AND, 0, 32'hFF, 32'h0F, 1, mk(32'h0F, 0, 0, 0, 0, 0));
      chk("acc_legal", 64'(last_acc), 64'd1); chk("pop_illegal", 64'(last_pop), 64'd1);
      cyc(0, FN_ADD, 0, 0, 0, 1, nil);
      chk("pop_legal", 64'(last_pop), 64'd1);
      chk("sb_final", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
